// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream bundle for cla_pipe_adder.
// The ovf signal exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, s, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, s, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, s, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, s, cout);
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CLA_WIDTH segment resolved per stage, global stall.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
  parameter int WIDTH     = 32,
  parameter int CLA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NSEG = WIDTH / CLA_WIDTH;
  localparam int CW   = CLA_WIDTH;

  // Returns {carry_out, sum}; every carry is a flat generate/propagate product term.
  function automatic logic [CW:0] cla_seg(input logic [CW-1:0] x,
                                          input logic [CW-1:0] y,
                                          input logic          ci);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    logic          gen_any;
    logic          prop_all;
    // NOTE: blocking assignments are right for combinational temporaries evaluated in order;
    // every state register below uses non-blocking so all stages sample pre-edge values.
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CW; i++) begin
      gen_any  = 1'b0;
      prop_all = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gen_any  = gen_any | (prop_all & g[j]);
        prop_all = prop_all & p[j];
      end
      c[i+1] = gen_any | (prop_all & ci);
    end
    return {c[CW], p ^ c[CW-1:0]};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign c_eff        = bus.sub | bus.cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int RW = (k + 1) * CW;

    logic          v_in;
    logic          c_in;
    logic [CW-1:0] a_seg;
    logic [CW-1:0] b_seg;
    logic [CW:0]   seg;
    logic [RW-1:0] r_d;
    logic          v_q;
    logic          c_q;
    logic [RW-1:0] r_q;

    if (k == 0) begin : g_first
      assign v_in  = bus.in_valid;
      assign c_in  = c_eff;
      assign a_seg = bus.a[CW-1:0];
      assign b_seg = b_eff[CW-1:0];
      assign r_d   = seg[CW-1:0];
    end else begin : g_next
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign a_seg = g_stage[k-1].g_skew.a_q[CW-1:0];
      assign b_seg = g_stage[k-1].g_skew.b_q[CW-1:0];
      // Deskew: finished lower segments ride along underneath the new one.
      assign r_d   = {seg[CW-1:0], g_stage[k-1].r_q};
    end

    assign seg = cla_seg(a_seg, b_seg, c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: datapath registers are reset too so s/cout read 0 straight out of reset.
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= seg[CW];
        r_q <= r_d;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      localparam int OW = WIDTH - RW;

      logic [OW-1:0] a_d;
      logic [OW-1:0] b_d;
      logic [OW-1:0] a_q;
      logic [OW-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = bus.a[WIDTH-1:CW];
        assign b_d = b_eff[WIDTH-1:CW];
      end else begin : g_src
        assign a_d = g_stage[k-1].g_skew.a_q[OW+CW-1:CW];
        assign b_d = g_stage[k-1].g_skew.b_q[OW+CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef CLA_PIPE_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (a_seg[CW-1] == b_seg[CW-1]) & (seg[CW-1] != a_seg[CW-1]);
        end
      end
    end
`endif
  end

  assign bus.out_valid = g_stage[NSEG-1].v_q;
  assign bus.s         = g_stage[NSEG-1].r_q;
  assign bus.cout      = g_stage[NSEG-1].c_q;
`ifdef CLA_PIPE_OVF_EN
  assign bus.ovf       = g_stage[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed latency/stall/reset steps plus random traffic
// scored against an arithmetic reference model (define CLA_PIPE_OVF_EN to cover ovf).
module tb_cla_pipe_adder;
  localparam int WIDTH     = 32;
  localparam int CLA_WIDTH = 8;
  localparam int NSEG      = WIDTH / CLA_WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  res_t exp_q[$];

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_adder #(.WIDTH(WIDTH), .CLA_WIDTH(CLA_WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Reference: plain wide arithmetic, independent of segmenting.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [WIDTH:0] w;
    longint      sa;
    longint      sb;
    longint      sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      w      = {1'b0, a} - {1'b0, b};
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      w      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      r.cout = w[WIDTH];
      sr     = sa + sb + longint'(cin);
    end
    r.s   = w[WIDTH-1:0];
    r.ovf = (sr > longint'(32'h7FFF_FFFF)) || (sr < -longint'(32'h8000_0000));
    return r;
  endfunction

  task automatic check_w(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check_b("sb_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_w("sb_s", bus.s, e.s);
          check_b("sb_cout", bus.cout, e.cout);
`ifdef CLA_PIPE_OVF_EN
          check_b("sb_ovf", bus.ovf, e.ovf);
`endif
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                       input logic cin_i, input logic sub_i);
    bus.in_valid = 1'b1;
    bus.a        = a_i;
    bus.b        = b_i;
    bus.cin      = cin_i;
    bus.sub      = sub_i;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check_b(tag, bus.in_ready, 1'b1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                      input logic cin_i, input logic sub_i);
    drive(a_i, b_i, cin_i, sub_i);
    wait_ready("send_ready");
    step();
  endtask

  task automatic wait_out(input string tag, input logic [WIDTH-1:0] exp_s, input logic exp_cout);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check_b({tag, "_valid"}, bus.out_valid, 1'b1);
    check_w({tag, "_s"}, bus.s, exp_s);
    check_b({tag, "_cout"}, bus.cout, exp_cout);
  endtask

  task automatic drain(input string tag, input int n0, input int n_exp);
    repeat (NSEG) @(negedge clk);
    step();
    check_w({tag, "_count"}, n_out - n0, n_exp);
    check_w({tag, "_empty"}, exp_q.size(), 0);
    check_b({tag, "_idle"}, bus.out_valid, 1'b0);
  endtask

  initial begin : stimulus
    int   n0;
    int   c0;
    res_t first;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    logic rs;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    check_b("rst_out_valid", bus.out_valid, 1'b0);
    check_w("rst_s", bus.s, '0);
    check_b("rst_cout", bus.cout, 1'b0);
    check_b("rst_in_ready", bus.in_ready, 1'b1);
`ifdef CLA_PIPE_OVF_EN
    check_b("rst_ovf", bus.ovf, 1'b0);
`endif
    step();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    // Wrap-around add and exact latency: valid only after the (NSEG-1)th edge past accept.
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check_b("t1_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < NSEG - 1; i++) begin
      @(negedge clk);
      check_b("t1_early", bus.out_valid, 1'b0);
    end
    @(negedge clk);
    check_b("t1_valid", bus.out_valid, 1'b1);
    check_w("t1_s", bus.s, 32'h0);
    check_b("t1_cout", bus.cout, 1'b1);
    step();

    // Subtract with and without borrow; cin must be ignored.
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'd7, 32'd5, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    wait_out("t2a", 32'hFFFF_FFFE, 1'b0);
    step();
    wait_out("t2b", 32'h0000_0002, 1'b1);
    step();

    // Back-to-back random traffic at one op per cycle.
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 200; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    check_w("t3_accept_cycles", cyc - c0, 200);
    bus.in_valid = 1'b0;
    drain("t3", n0, 200);

    // Fill the pipe with the consumer stalled, hold for 3 cycles, then release.
    n0            = n_out;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i == 0) first = model(ra, rb, rc, rs);
      send(ra, rb, rc, rs);
    end
    drive($urandom, $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_b("t4_in_ready", bus.in_ready, 1'b0);
      check_b("t4_valid", bus.out_valid, 1'b1);
      check_w("t4_s_hold", bus.s, first.s);
      check_b("t4_cout_hold", bus.cout, first.cout);
      step();
    end
    bus.out_ready = 1'b1;
    wait_ready("t4_resume");
    step();
    bus.in_valid = 1'b0;
    drain("t4", n0, NSEG + 1);

    // Reset with one result presented and the rest in flight: everything is discarded.
    n0 = n_out;
    for (int i = 0; i < NSEG; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    bus.in_valid = 1'b0;
    check_b("t5_valid_before_rst", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("t5_rst_valid", bus.out_valid, 1'b0);
    check_w("t5_rst_s", bus.s, '0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * NSEG; i++) begin
      @(negedge clk);
      check_b("t5_no_stale", bus.out_valid, 1'b0);
    end
    step();
    check_w("t5_no_emit", n_out - n0, 0);
    send(32'd100, 32'd23, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    wait_out("t5_new", 32'd124, 1'b0);
    step();

`ifdef CLA_PIPE_OVF_EN
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h1, 32'h1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    wait_out("t6a", 32'h8000_0000, 1'b0);
    check_b("t6a_ovf", bus.ovf, 1'b1);
    step();
    wait_out("t6b", 32'h7FFF_FFFF, 1'b1);
    check_b("t6b_ovf", bus.ovf, 1'b1);
    step();
    wait_out("t6c", 32'h0000_0002, 1'b0);
    check_b("t6c_ovf", bus.ovf, 1'b0);
    step();
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
